// File: rtl/encoder_scan_ctrl.sv
// Round-robin quadrature scanner: one shared debounce/decode engine visits each
// encoder channel per slot tick, counts detents and raises change flags for the host.
module encoder_scan_ctrl #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 1000,
  parameter int DEB      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] enc_x,
  input  logic [N_CH-1:0] enc_y,
  input  logic            scan_en,
  input  logic            rd_en,
  input  logic            rd_clr,
  input  logic [3:0]      rd_addr,
  output logic [7:0]      rd_data,
  output logic            rd_valid,
  output logic [N_CH-1:0] chg,
  output logic            irq
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] x_meta_q, x_sync_q, y_meta_q, y_sync_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]   ch_sel_q, ch_sel_d;
  logic [1:0]      stable_q [N_CH];
  logic [1:0]      stable_d [N_CH];
  logic [1:0]      cand_q   [N_CH];
  logic [1:0]      cand_d   [N_CH];
  logic [2:0]      run_q    [N_CH];
  logic [2:0]      run_d    [N_CH];
  logic [7:0]      cnt_q    [N_CH];
  logic [7:0]      cnt_d    [N_CH];
  logic [N_CH-1:0] chg_q, chg_d;
  logic            irq_q, irq_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            tick;
  logic [1:0]      samp;
  logic [2:0]      run_nx;

  always_comb begin
    tick       = scan_en && (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick_cnt_q;
    ch_sel_d   = ch_sel_q;
    stable_d   = stable_q;
    cand_d     = cand_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
    chg_d      = chg_q;
    irq_d      = |chg_q;
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? 8'h00 : rd_data_q;
    samp       = 2'b11;
    run_nx     = 3'd0;

    if (scan_en) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    if (tick) ch_sel_d = (ch_sel_q == CW'(N_CH - 1)) ? '0 : ch_sel_q + CW'(1);

    for (int i = 0; i < N_CH; i++) begin
      // Read sees the pre-update counter and drops the flag before any new count re-arms it.
      if (rd_en && rd_addr == 4'(i)) begin
        rd_data_d = cnt_q[i];
        chg_d[i]  = 1'b0;
      end
      if (tick && ch_sel_q == CW'(i)) begin
        samp   = {x_sync_q[i], y_sync_q[i]};
        run_nx = 3'd0;
        if (samp == stable_q[i]) begin
          cand_d[i] = samp;
        end else if (samp == cand_q[i]) begin
          run_nx = run_q[i] + 3'd1;
        end else begin
          cand_d[i] = samp;
          run_nx    = 3'd1;
        end
        run_d[i] = run_nx;
        if (run_nx == 3'(DEB)) begin
          stable_d[i] = samp;
          run_d[i]    = 3'd0;
          // Only leaving the 11 detent counts; direction comes from which phase drops first.
          if (stable_q[i] == 2'b11 && samp == 2'b10) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
            chg_d[i] = 1'b1;
          end else if (stable_q[i] == 2'b11 && samp == 2'b01) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
            chg_d[i] = 1'b1;
          end
        end
      end
      if (rd_en && rd_clr && rd_addr == 4'(i)) begin
        cnt_d[i] = 8'd0;
        chg_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_meta_q   <= '1;
      x_sync_q   <= '1;
      y_meta_q   <= '1;
      y_sync_q   <= '1;
      tick_cnt_q <= '0;
      ch_sel_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stable_q[i] <= 2'b11;
        cand_q[i]   <= 2'b11;
        run_q[i]    <= 3'd0;
        cnt_q[i]    <= 8'd0;
      end
      chg_q      <= '0;
      irq_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      x_meta_q   <= enc_x;
      x_sync_q   <= x_meta_q;
      y_meta_q   <= enc_y;
      y_sync_q   <= y_meta_q;
      tick_cnt_q <= tick_cnt_d;
      ch_sel_q   <= ch_sel_d;
      stable_q   <= stable_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      chg_q      <= chg_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign chg      = chg_q;
  assign irq      = irq_q;

endmodule
